rgb_pwm_driver: RTL
===================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning PWM period in clk cycles (100 us at 12 MHz).
REQ-002 SHALL have parameter LED_ACTIVE_LOW, default 1, meaning LED pins are lit when driven 0.
REQ-003 SHALL define DW = $clog2(PWM_INTERVAL)+1 as the duty width, so that PWM_INTERVAL itself is representable.
REQ-004 clk  input  1  system clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 enable  input  1  1 = PWM running; 0 = counter held and LEDs dark.
REQ-007 duty_r / duty_g / duty_b  input  DW each  requested on-time in cycles per period.
REQ-008 duty_valid  input  1  capture strobe for duty_r/g/b.
REQ-009 led_r / led_g / led_b  output  1 each  registered LED pin drive.
REQ-010 period_start  output  1  one-cycle pulse marking the first output cycle of each period.
REQ-011 update_pending  output  1  captured duties are waiting for the next period boundary.

Function
REQ-012 SHALL keep a period counter cnt running 0..PWM_INTERVAL-1, incrementing every cycle while enable=1, and wrapping from PWM_INTERVAL-1 to 0.
REQ-013 SHALL hold active duties act_r/g/b, which change only at a period boundary (cnt==PWM_INTERVAL-1 with enable=1), so that no period is ever torn.
REQ-014 SHALL load any cycle with duty_valid=1 into pending registers and set update_pending.
- Last write wins.
- No backpressure: duty_valid is always accepted.
REQ-015 SHALL saturate captured duty values above PWM_INTERVAL to PWM_INTERVAL.
REQ-016 At a boundary with update_pending=1, SHALL copy pending into active and clear update_pending in the same clock edge.
REQ-017 SHALL handle duty_valid=1 on a boundary cycle as follows:
- The strobed values go directly into active.
- update_pending ends 0.
REQ-018 SHALL compute each channel raw_on = (cnt < act_x).
- duty 0 = always off.
- duty PWM_INTERVAL = always on.
REQ-019 SHALL register the LED outputs as led_x <= raw_on XOR LED_ACTIVE_LOW, giving 1-cycle latency from cnt to pin.
REQ-020 SHALL register period_start <= (cnt==0 && enable), so it is aligned with the led_x cycle that reflects cnt==0.
REQ-021 While enable=0, the block SHALL:
- hold cnt at 0;
- drive led_x to the inactive level (1 if LED_ACTIVE_LOW);
- hold period_start at 0;
- continue capturing duty_valid;
- perform no boundary transfer.
REQ-022 On enable 0->1, the first period SHALL start at cnt=0, and the pending-to-active transfer SHALL occur at the end of that first period.
REQ-023 Counter and comparisons SHALL be unsigned; cnt width is $clog2(PWM_INTERVAL).

Reset
REQ-024 While rst=1, the block SHALL immediately (asynchronously) set:
- cnt=0;
- act_r/g/b=0;
- pending=0 and update_pending=0;
- period_start=0;
- led_x = inactive level (1 with default parameter).
REQ-025 Reset asserted mid-period SHALL discard pending updates; after release, outputs stay dark until a new duty_valid is applied at a boundary.
REQ-026 After rst deasserts with enable=1, the first clk edge SHALL begin counting from cnt=0.

Verification (PWM_INTERVAL=10, LED_ACTIVE_LOW=1)
REQ-027 Reset, enable=1, duty_valid pulse with r=3,g=0,b=10 -> update_pending=1 until boundary; next period: led_r low 3 cycles then high 7, led_g high 10, led_b low 10.
REQ-028 Strobe r=5 at cnt=2, then r=7 at cnt=6 -> current period unchanged; next period led_r low exactly 7 cycles (last write wins).
REQ-029 duty_valid with r=4 on the cnt=9 boundary cycle -> update_pending stays 0; the following period has led_r low 4 cycles.
REQ-030 duty_r=15 -> saturates to 10; led_r low all 10 cycles of every period, with no glitch at the wrap.
REQ-031 Drop enable mid-period with r=6 active -> all LEDs 1 next cycle, period_start 0, cnt 0; re-enable -> period_start pulses one cycle later and led_r is low 6 cycles.
REQ-032 Assert rst asynchronously mid-period with pending set -> LEDs 1 and update_pending 0 before the next clk edge; after release, LEDs stay 1 with no new duty_valid.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver with tear-free duty updates at period boundaries.
// Duties strobed mid-period wait in pending registers until the counter wraps.
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL   = 1200,
    parameter bit LED_ACTIVE_LOW = 1'b1,
    localparam int CW = $clog2(PWM_INTERVAL),
    localparam int DW = CW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] duty_r,
    input  logic [DW-1:0] duty_g,
    input  logic [DW-1:0] duty_b,
    input  logic          duty_valid,
    output logic          led_r,
    output logic          led_g,
    output logic          led_b,
    output logic          period_start,
    output logic          update_pending
);

    localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] DUTY_MAX  = DW'(PWM_INTERVAL);
    localparam logic          LED_IDLE  = LED_ACTIVE_LOW;

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_act_r, r_act_g, r_act_b;
    logic [DW-1:0] r_pend_r, r_pend_g, r_pend_b;
    logic          r_update_pending;
    logic          r_led_r, r_led_g, r_led_b;
    logic          r_period_start;

    logic          w_boundary;
    logic [DW-1:0] w_cnt_ext;
    logic [DW-1:0] w_sat_r, w_sat_g, w_sat_b;
    logic          w_on_r, w_on_g, w_on_b;

    assign w_boundary = enable && (r_cnt == CNT_LAST);
    assign w_cnt_ext  = {1'b0, r_cnt};

    // Requests beyond a full period collapse to "always on".
    assign w_sat_r = (duty_r > DUTY_MAX) ? DUTY_MAX : duty_r;
    assign w_sat_g = (duty_g > DUTY_MAX) ? DUTY_MAX : duty_g;
    assign w_sat_b = (duty_b > DUTY_MAX) ? DUTY_MAX : duty_b;

    assign w_on_r = (w_cnt_ext < r_act_r);
    assign w_on_g = (w_cnt_ext < r_act_g);
    assign w_on_b = (w_cnt_ext < r_act_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable || w_boundary) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A strobe landing on the boundary bypasses pending and goes straight to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_r          <= '0;
            r_act_g          <= '0;
            r_act_b          <= '0;
            r_pend_r         <= '0;
            r_pend_g         <= '0;
            r_pend_b         <= '0;
            r_update_pending <= 1'b0;
        end else if (w_boundary) begin
            if (duty_valid) begin
                r_act_r <= w_sat_r;
                r_act_g <= w_sat_g;
                r_act_b <= w_sat_b;
            end else if (r_update_pending) begin
                r_act_r <= r_pend_r;
                r_act_g <= r_pend_g;
                r_act_b <= r_pend_b;
            end
            r_update_pending <= 1'b0;
        end else if (duty_valid) begin
            r_pend_r         <= w_sat_r;
            r_pend_g         <= w_sat_g;
            r_pend_b         <= w_sat_b;
            r_update_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_r        <= LED_IDLE;
            r_led_g        <= LED_IDLE;
            r_led_b        <= LED_IDLE;
            r_period_start <= 1'b0;
        end else if (enable) begin
            r_led_r        <= w_on_r ^ LED_ACTIVE_LOW;
            r_led_g        <= w_on_g ^ LED_ACTIVE_LOW;
            r_led_b        <= w_on_b ^ LED_ACTIVE_LOW;
            r_period_start <= (r_cnt == '0);
        end else begin
            r_led_r        <= LED_IDLE;
            r_led_g        <= LED_IDLE;
            r_led_b        <= LED_IDLE;
            r_period_start <= 1'b0;
        end
    end

    assign led_r          = r_led_r;
    assign led_g          = r_led_g;
    assign led_b          = r_led_b;
    assign period_start   = r_period_start;
    assign update_pending = r_update_pending;

endmodule
